// File: rtl/serial_receiver_pkg.sv
// serial_receiver_pkg: shared state encoding, defaults and sizing helper for the serial receiver
package serial_receiver_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic {ST_IDLE, ST_RECV} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_receiver_if.sv
// serial_receiver_if: serial bit stream in, word holding register and status out
interface serial_receiver_if import serial_receiver_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic Din;
  logic DinValid;
  logic ReadAck;
  logic [WIDTH-1:0] DataOut;
  logic RxValid;
  logic RxDone;
  logic RxBusy;
  logic RxError;
  logic Overrun;
  modport master(output Din, DinValid, ReadAck, input DataOut, RxValid, RxDone, RxBusy, RxError, Overrun);
  modport slave(input Din, DinValid, ReadAck, output DataOut, RxValid, RxDone, RxBusy, RxError, Overrun);
endinterface

// File: rtl/serial_rx_gap_timer.sv
// serial_rx_gap_timer: saturating count of idle cycles inside a frame; expired marks the cycle the gap reaches TIMEOUT
module serial_rx_gap_timer import serial_receiver_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  if (TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused = ^{Clk, Reset, clear, count_en};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int GW = clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] LIMIT = GW'(TIMEOUT);
    logic [GW-1:0] gap;
    always_ff @(posedge Clk or posedge Reset)
      if (Reset) gap <= '0;
      else if (clear) gap <= '0;
      else if (count_en && gap != LIMIT) gap <= gap + 1'b1;
    // fires on the idle cycle that brings the gap up to TIMEOUT, so the error is registered on that same edge
    assign expired = count_en && gap == LIMIT - 1'b1;
  end
endmodule

// File: rtl/serial_receiver.sv
// serial_receiver: MSB-first deserialiser with valid/ack holding register, gap timeout and overrun flag
module serial_receiver import serial_receiver_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic Clk,
  input logic Reset,
  serial_receiver_if.slave bus
);
  localparam int BW = clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  state_t state;
  logic [WIDTH-2:0] shift;
  logic [WIDTH-1:0] data_out, next_word;
  logic [BW-1:0] bitcnt;
  logic rx_valid, rx_done, rx_busy, rx_error, overrun, expired;
  assign next_word = {shift, bus.Din};
  serial_rx_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
    .Clk(Clk),
    .Reset(Reset),
    .clear(bus.DinValid || state != ST_RECV),
    .count_en(state == ST_RECV && !bus.DinValid),
    .expired(expired)
  );
  // no start bit on the link: any valid bit in IDLE opens a frame with bitcnt at 0
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= ST_IDLE;
      shift <= '0;
      bitcnt <= '0;
      data_out <= '0;
      rx_valid <= 1'b0;
      rx_done <= 1'b0;
      rx_busy <= 1'b0;
      rx_error <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_error <= 1'b0;
      if (bus.ReadAck && rx_valid) begin
        rx_valid <= 1'b0;
        overrun <= 1'b0;
      end
      if (bus.DinValid) begin
        shift <= next_word[WIDTH-2:0];
        if (bitcnt == LAST) begin
          data_out <= next_word;
          rx_valid <= 1'b1;
          rx_done <= 1'b1;
          bitcnt <= '0;
          state <= ST_IDLE;
          rx_busy <= 1'b0;
          if (rx_valid && !bus.ReadAck) overrun <= 1'b1;
        end else begin
          bitcnt <= bitcnt + 1'b1;
          state <= ST_RECV;
          rx_busy <= 1'b1;
        end
      end else if (expired) begin
        bitcnt <= '0;
        state <= ST_IDLE;
        rx_busy <= 1'b0;
        rx_error <= 1'b1;
      end
    end
  assign bus.DataOut = data_out;
  assign bus.RxValid = rx_valid;
  assign bus.RxDone = rx_done;
  assign bus.RxBusy = rx_busy;
  assign bus.RxError = rx_error;
  assign bus.Overrun = overrun;
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: scenario tasks with a word scoreboard checked on every RxDone pulse
module tb_serial_receiver;
  localparam int W = 32;
  localparam int TO = 8;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  serial_receiver_if #(.WIDTH(W)) bus();
  serial_receiver #(.WIDTH(W), .TIMEOUT(TO)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (bus.RxError) err_pulses++;
    if (bus.RxDone) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: DataOut=%h with no word expected", bus.DataOut);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.DataOut !== exp_w) begin
          errors++;
          $display("FAIL scoreboard_word: DataOut=%h expected %h", bus.DataOut, exp_w);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic send_bits(input logic [W-1:0] w, input int n, input int gap, input bit ack_last);
    for (int i = 0; i < n; i++) begin
      bus.Din = w[W-1-i];
      bus.DinValid = 1'b1;
      bus.ReadAck = ack_last && i == n - 1;
      @(posedge Clk); #1;
      bus.DinValid = 1'b0;
      bus.ReadAck = 1'b0;
      if (i != n - 1) repeat (gap) begin @(posedge Clk); #1; end
    end
  endtask
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit ack_last);
    exp_q.push_back(w);
    send_bits(w, W, gap, ack_last);
  endtask
  task automatic ack;
    bus.ReadAck = 1'b1;
    @(posedge Clk); #1;
    bus.ReadAck = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge Clk);
    #1;
    checks += 6;
    if (bus.DataOut !== '0) begin errors++; $display("FAIL reset_dataout: got %h want 0", bus.DataOut); end
    if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid: got %b want 0", bus.RxValid); end
    if (bus.RxDone !== 1'b0) begin errors++; $display("FAIL reset_rxdone: got %b want 0", bus.RxDone); end
    if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL reset_rxbusy: got %b want 0", bus.RxBusy); end
    if (bus.RxError !== 1'b0) begin errors++; $display("FAIL reset_rxerror: got %b want 0", bus.RxError); end
    if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.Overrun); end
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask
  task automatic test_basic;
    send_word(32'hA5A50F3C, 0, 1'b0);
    checks += 5;
    if (bus.RxDone !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", bus.RxDone); end
    if (bus.DataOut !== 32'hA5A50F3C) begin errors++; $display("FAIL basic_data: got %h want a5a50f3c", bus.DataOut); end
    if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.RxValid); end
    if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", bus.RxBusy); end
    if (bus.RxError !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", bus.RxError); end
    @(posedge Clk); #1;
    checks++;
    if (bus.RxDone !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.RxDone); end
    ack;
    checks++;
    if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL basic_ack: RxValid got %b want 0", bus.RxValid); end
  endtask
  task automatic test_sparse;
    int p0 = err_pulses;
    send_word(32'h12345678, 3, 1'b0);
    checks += 3;
    if (bus.DataOut !== 32'h12345678) begin errors++; $display("FAIL sparse_data: got %h want 12345678", bus.DataOut); end
    if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL sparse_valid: got %b want 1", bus.RxValid); end
    if (err_pulses !== p0) begin errors++; $display("FAIL sparse_error: %0d RxError pulses want 0", err_pulses - p0); end
  endtask
  task automatic test_timeout;
    int p0 = err_pulses;
    send_bits(32'hB6D00000, 10, 0, 1'b0);
    checks++;
    if (bus.RxBusy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid: got %b want 1", bus.RxBusy); end
    repeat (TO - 1) begin @(posedge Clk); #1; end
    checks += 2;
    if (bus.RxError !== 1'b0) begin errors++; $display("FAIL timeout_early: RxError got %b want 0", bus.RxError); end
    if (bus.RxBusy !== 1'b1) begin errors++; $display("FAIL timeout_busy_hold: got %b want 1", bus.RxBusy); end
    @(posedge Clk); #1;
    checks += 4;
    if (bus.RxError !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", bus.RxError); end
    if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", bus.RxBusy); end
    if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL timeout_valid: got %b want 1", bus.RxValid); end
    if (bus.DataOut !== 32'h12345678) begin errors++; $display("FAIL timeout_data: got %h want 12345678", bus.DataOut); end
    @(posedge Clk); #1;
    checks += 2;
    if (bus.RxError !== 1'b0) begin errors++; $display("FAIL timeout_pulse: RxError got %b want 0", bus.RxError); end
    if (err_pulses !== p0 + 1) begin errors++; $display("FAIL timeout_count: %0d pulses want 1", err_pulses - p0); end
    ack;
    send_word(32'hDEADBEEF, 0, 1'b0);
    checks += 3;
    if (bus.DataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_recover: got %h want deadbeef", bus.DataOut); end
    if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL timeout_recover_valid: got %b want 1", bus.RxValid); end
    if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL timeout_recover_ovr: got %b want 0", bus.Overrun); end
    ack;
  endtask
  task automatic test_back_to_back;
    send_word(32'h00000001, 0, 1'b0);
    send_word(32'hFFFFFFFF, 0, 1'b0);
    checks += 3;
    if (bus.DataOut !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_data: got %h want ffffffff", bus.DataOut); end
    if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", bus.RxValid); end
    if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", bus.Overrun); end
    ack;
    checks += 2;
    if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL b2b_ack_valid: got %b want 0", bus.RxValid); end
    if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL b2b_ack_overrun: got %b want 0", bus.Overrun); end
  endtask
  task automatic test_ack_collision;
    send_word(32'h0F0F0F0F, 0, 1'b0);
    send_word(32'h3C3CA5A5, 0, 1'b1);
    checks += 3;
    if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL collide_valid: got %b want 1", bus.RxValid); end
    if (bus.DataOut !== 32'h3C3CA5A5) begin errors++; $display("FAIL collide_data: got %h want 3c3ca5a5", bus.DataOut); end
    if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL collide_overrun: got %b want 0", bus.Overrun); end
  endtask
  task automatic test_async_reset;
    send_bits(32'h13572468, 16, 0, 1'b0);
    checks++;
    if (bus.RxBusy !== 1'b1) begin errors++; $display("FAIL areset_busy_before: got %b want 1", bus.RxBusy); end
    #2 Reset = 1'b1;
    #1;
    checks += 4;
    if (bus.DataOut !== '0) begin errors++; $display("FAIL areset_data: got %h want 0", bus.DataOut); end
    if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", bus.RxValid); end
    if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", bus.RxBusy); end
    if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL areset_overrun: got %b want 0", bus.Overrun); end
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    exp_q.push_back(32'hCAFEF00D);
    send_bits(32'hCAFEF00D, W - 1, 0, 1'b0);
    checks += 2;
    if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL areset_31_valid: got %b want 0", bus.RxValid); end
    if (bus.RxBusy !== 1'b1) begin errors++; $display("FAIL areset_31_busy: got %b want 1", bus.RxBusy); end
    send_bits(32'h80000000, 1, 0, 1'b0);
    checks += 3;
    if (bus.RxDone !== 1'b1) begin errors++; $display("FAIL areset_32_done: got %b want 1", bus.RxDone); end
    if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL areset_32_valid: got %b want 1", bus.RxValid); end
    if (bus.DataOut !== 32'hCAFEF00D) begin errors++; $display("FAIL areset_32_data: got %h want cafef00d", bus.DataOut); end
  endtask
  initial begin
    bus.Din = 1'b0;
    bus.DinValid = 1'b0;
    bus.ReadAck = 1'b0;
    test_reset;
    test_basic;
    test_sparse;
    test_timeout;
    test_back_to_back;
    test_ack_collision;
    test_async_reset;
    @(posedge Clk); #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d words never received", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
